// File: rtl/ah_div_pipe_arbiter.sv
// ---------------------------------------------------------------------------
// ah_div_pipe_arbiter
//
// Shares one pipelined signed divider among NREQ requesters. One request is
// granted per cycle in round-robin order, its operands are registered onto
// the divider inputs, and the requester index rides a tag pipeline matched to
// the divider latency. Each returning quotient is steered back to its
// originating requester as a one-cycle resp_valid pulse.
//
// Configuration macro:
//   AH_DIV_ARB_PRIO0_EN  when defined, requester 0 has absolute priority and
//                        requesters 1..NREQ-1 share round-robin among
//                        themselves; when undefined, plain round-robin.
//
// Ports:
//   clk, rstn                 clock (rising edge), async active-low reset
//   enable                    1 = new grants allowed
//   req_valid/_dividend/_divisor   per-requester request and packed operands
//   req_ready                 one-hot combinational grant
//   resp_valid/_quotient/_div_by_zero   registered one-hot response pulse
//   div_start/_dividend/_divisor        registered issue to the divider
//   div_data_valid/_quotient/_div_by_zero   result from the divider
//   busy                      work in the issue, tag or response stages
//   tag_error                 sticky divider/tag-pipeline mismatch
// ---------------------------------------------------------------------------
module ah_div_pipe_arbiter #(
    parameter int NREQ    = 4,
    parameter int WIDTH   = 8,
    parameter int LATENCY = 11,
    parameter int TAGW    = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  enable,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_dividend,
    input  logic [NREQ*WIDTH-1:0] req_divisor,
    output logic [NREQ-1:0]       req_ready,
    output logic [NREQ-1:0]       resp_valid,
    output logic [WIDTH-1:0]      resp_quotient,
    output logic                  resp_div_by_zero,
    output logic                  div_start,
    output logic [WIDTH-1:0]      div_dividend,
    output logic [WIDTH-1:0]      div_divisor,
    input  logic                  div_data_valid,
    input  logic [WIDTH-1:0]      div_quotient,
    input  logic                  div_div_by_zero,
    output logic                  busy,
    output logic                  tag_error
);

    localparam int CNTW = $clog2(LATENCY + 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [TAGW-1:0]                ptr_q,        ptr_d;
    logic                           start_q,      start_d;
    logic [WIDTH-1:0]               dividend_q,   dividend_d;
    logic [WIDTH-1:0]               divisor_q,    divisor_d;
    logic [TAGW-1:0]                issue_tag_q,  issue_tag_d;
    logic [LATENCY-1:0]             tag_v_q,      tag_v_d;
    logic [LATENCY-1:0][TAGW-1:0]   tag_id_q,     tag_id_d;
    logic [CNTW-1:0]                ignore_q,     ignore_d;
    logic                           tag_err_q,    tag_err_d;
    logic [NREQ-1:0]                resp_valid_q, resp_valid_d;
    logic [WIDTH-1:0]               resp_quot_q,  resp_quot_d;
    logic                           resp_dz_q,    resp_dz_d;

    // ------------------------------------------------------------------
    // Grant: first valid requester searching upward from ptr+1, wrapping.
    // ------------------------------------------------------------------
    logic [NREQ-1:0]  grant;
    logic [TAGW-1:0]  grant_idx;
    logic             handshake;
    logic [WIDTH-1:0] sel_dividend;
    logic [WIDTH-1:0] sel_divisor;

    // NOTE: every signal written in an always_comb gets a default at the top
    // of the block, so no path through it can leave a value held (latch).
    always_comb begin : arbiter
        int              pos;
        logic [TAGW-1:0] cand;
        logic            eligible;
        logic            found;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        pos       = 0;
        cand      = '0;
        eligible  = 1'b0;
`ifdef AH_DIV_ARB_PRIO0_EN
        // Requester 0 wins outright; the rotating search below skips it.
        if (enable && req_valid[0]) begin
            grant[0] = 1'b1;
            found    = 1'b1;
        end
`endif
        for (int k = 1; k <= NREQ; k++) begin
            pos = int'(ptr_q) + k;
            if (pos >= NREQ) begin
                pos = pos - NREQ;
            end
            cand = TAGW'(pos);
`ifdef AH_DIV_ARB_PRIO0_EN
            eligible = (cand != '0);
`else
            eligible = 1'b1;
`endif
            if (!found && enable && eligible && req_valid[cand]) begin
                grant[cand] = 1'b1;
                grant_idx   = cand;
                found       = 1'b1;
            end
        end
    end

    // Operand select from the one-hot grant.
    always_comb begin : operand_mux
        sel_dividend = '0;
        sel_divisor  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_dividend = req_dividend[i*WIDTH +: WIDTH];
                sel_divisor  = req_divisor[i*WIDTH +: WIDTH];
            end
        end
    end

    // Grants are suppressed while reset is held so every output reads 0.
    assign req_ready = grant & {NREQ{rstn}};
    assign handshake = |req_ready;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    logic            head_v;
    logic [TAGW-1:0] head_tag;

    assign head_v   = tag_v_q[LATENCY-1];
    assign head_tag = tag_id_q[LATENCY-1];

    always_comb begin : next_state
        // Pointer follows the granted index.
        ptr_d = ptr_q;
`ifdef AH_DIV_ARB_PRIO0_EN
        // A requester-0 grant leaves the round-robin position untouched.
        if (handshake && (grant_idx != '0)) begin
            ptr_d = grant_idx;
        end
`else
        if (handshake) begin
            ptr_d = grant_idx;
        end
`endif

        // Issue stage: operands hold when nothing is granted.
        start_d     = handshake;
        dividend_d  = handshake ? sel_dividend : dividend_q;
        divisor_d   = handshake ? sel_divisor  : divisor_q;
        issue_tag_d = handshake ? grant_idx    : issue_tag_q;

        // Tag pipeline enters with div_start; its last stage lines up with
        // the cycle the divider raises div_data_valid for that operation.
        tag_v_d  = {tag_v_q[LATENCY-2:0], start_q};
        tag_id_d = {tag_id_q[LATENCY-2:0], issue_tag_q};

        // Post-reset ignore window counts down to zero and stays there.
        ignore_d = (ignore_q != '0) ? (ignore_q - CNTW'(1)) : ignore_q;

        tag_err_d = tag_err_q;
        if ((ignore_q == '0) && (div_data_valid != head_v)) begin
            tag_err_d = 1'b1;
        end

        // A result with no matching tag is dropped (only tag_error reports it).
        resp_valid_d = '0;
        resp_quot_d  = resp_quot_q;
        resp_dz_d    = resp_dz_q;
        if (div_data_valid && head_v) begin
            resp_valid_d = NREQ'(1) << head_tag;
            resp_quot_d  = div_quotient;
            resp_dz_d    = div_div_by_zero;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ptr_q        <= TAGW'(NREQ - 1);
            start_q      <= 1'b0;
            dividend_q   <= '0;
            divisor_q    <= '0;
            issue_tag_q  <= '0;
            // NOTE: the tag pipeline is a shift register, not a RAM, and is
            // reset in full: its valid bits decide whether a result is routed
            // and must discard in-flight work on reset.
            tag_v_q      <= '0;
            tag_id_q     <= '0;
            ignore_q     <= CNTW'(LATENCY);
            tag_err_q    <= 1'b0;
            resp_valid_q <= '0;
            resp_quot_q  <= '0;
            resp_dz_q    <= 1'b0;
        end else begin
            ptr_q        <= ptr_d;
            start_q      <= start_d;
            dividend_q   <= dividend_d;
            divisor_q    <= divisor_d;
            issue_tag_q  <= issue_tag_d;
            tag_v_q      <= tag_v_d;
            tag_id_q     <= tag_id_d;
            ignore_q     <= ignore_d;
            tag_err_q    <= tag_err_d;
            resp_valid_q <= resp_valid_d;
            resp_quot_q  <= resp_quot_d;
            resp_dz_q    <= resp_dz_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign div_start        = start_q;
    assign div_dividend     = dividend_q;
    assign div_divisor      = divisor_q;
    assign resp_valid       = resp_valid_q;
    assign resp_quotient    = resp_quot_q;
    assign resp_div_by_zero = resp_dz_q;
    assign tag_error        = tag_err_q;
    assign busy             = start_q | (|tag_v_q) | (|resp_valid_q);

endmodule

// File: tb/tb_ah_div_pipe_arbiter.sv
// ---------------------------------------------------------------------------
// Testbench for ah_div_pipe_arbiter: drives requests, models the external
// pipelined divider, and predicts grants and responses from the arbitration
// rules with a queue-based reference model.
// ---------------------------------------------------------------------------
module tb_ah_div_pipe_arbiter;

    localparam int NREQ = 4;
    localparam int W    = 8;
    localparam int L    = 11;

    logic              clk          = 1'b0;
    logic              rstn         = 1'b0;
    logic              enable       = 1'b0;
    logic [NREQ-1:0]   req_valid    = '0;
    logic [NREQ*W-1:0] req_dividend = '0;
    logic [NREQ*W-1:0] req_divisor  = '0;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ-1:0]   resp_valid;
    logic [W-1:0]      resp_quotient;
    logic              resp_div_by_zero;
    logic              div_start;
    logic [W-1:0]      div_dividend;
    logic [W-1:0]      div_divisor;
    logic              div_data_valid;
    logic [W-1:0]      div_quotient;
    logic              div_div_by_zero;
    logic              busy;
    logic              tag_error;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   resp_cnt = 0;
    logic inject   = 1'b0;

    ah_div_pipe_arbiter #(.NREQ(NREQ), .WIDTH(W), .LATENCY(L), .TAGW(2)) dut (
        .clk              (clk),
        .rstn             (rstn),
        .enable           (enable),
        .req_valid        (req_valid),
        .req_dividend     (req_dividend),
        .req_divisor      (req_divisor),
        .req_ready        (req_ready),
        .resp_valid       (resp_valid),
        .resp_quotient    (resp_quotient),
        .resp_div_by_zero (resp_div_by_zero),
        .div_start        (div_start),
        .div_dividend     (div_dividend),
        .div_divisor      (div_divisor),
        .div_data_valid   (div_data_valid),
        .div_quotient     (div_quotient),
        .div_div_by_zero  (div_div_by_zero),
        .busy             (busy),
        .tag_error        (tag_error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- external divider model (not reset) ----------------
    function automatic logic [W-1:0] model_div(input logic [W-1:0] a, input logic [W-1:0] b);
        int ia;
        int ib;
        ia = int'($signed(a));
        ib = int'($signed(b));
        if (ib == 0) return '1;
        return W'(ia / ib);
    endfunction

    logic [L-1:0] m_v = '0;
    logic [W-1:0] m_q [L];
    logic         m_z [L];

    always @(posedge clk) begin
        m_v     <= {m_v[L-2:0], div_start};
        m_q[0]  <= model_div(div_dividend, div_divisor);
        m_z[0]  <= (div_divisor == '0);
        for (int s = 1; s < L; s++) begin
            m_q[s] <= m_q[s-1];
            m_z[s] <= m_z[s-1];
        end
    end

    assign div_data_valid  = m_v[L-1] | inject;
    assign div_quotient    = m_q[L-1];
    assign div_div_by_zero = m_z[L-1];

    // ---------------- reference model ----------------
    typedef struct {
        int tag;
        int quo;
        bit dz;
        int due;
    } exp_t;

    exp_t sb_q[$];
    int   ref_ptr = NREQ - 1;

    function automatic logic [NREQ-1:0] exp_grant(input logic [NREQ-1:0] v, input logic en);
        logic [NREQ-1:0] g;
        g = '0;
        if (!en) return g;
`ifdef AH_DIV_ARB_PRIO0_EN
        if (v[0]) begin
            g[0] = 1'b1;
            return g;
        end
`endif
        for (int k = 1; k <= NREQ; k++) begin
            int i;
            i = (ref_ptr + k) % NREQ;
`ifdef AH_DIV_ARB_PRIO0_EN
            if (i == 0) continue;
`endif
            if (v[i]) begin
                g[i] = 1'b1;
                return g;
            end
        end
        return g;
    endfunction

    task automatic note_grant(input logic [NREQ-1:0] g);
        exp_t e;
        int   a;
        int   b;
        for (int i = 0; i < NREQ; i++) begin
            if (g[i]) begin
                a     = int'($signed(req_dividend[i*W +: W]));
                b     = int'($signed(req_divisor[i*W +: W]));
                e.tag = i;
                e.dz  = (b == 0);
                e.quo = e.dz ? 0 : a / b;
                e.due = cyc + L + 2;
                sb_q.push_back(e);
`ifdef AH_DIV_ARB_PRIO0_EN
                if (i != 0) ref_ptr = i;
`else
                ref_ptr = i;
`endif
            end
        end
    endtask

    // Response scoreboard: every pulse must match the oldest outstanding grant.
    always @(negedge clk) begin : monitor
        exp_t            e;
        logic [NREQ-1:0] eo;
        if (rstn) begin
            while (sb_q.size() > 0 && sb_q[0].due < cyc) begin
                checks++;
                failures++;
                $display("FAIL resp_missing: requester %0d due cycle %0d, nothing seen by cycle %0d",
                         sb_q[0].tag, sb_q[0].due, cyc);
                void'(sb_q.pop_front());
            end
            if (resp_valid != '0) begin
                resp_cnt++;
                checks++;
                if (sb_q.size() == 0) begin
                    failures++;
                    $display("FAIL resp_unexpected: resp_valid=%b at cycle %0d, required none", resp_valid, cyc);
                end else begin
                    e  = sb_q.pop_front();
                    eo = NREQ'(1) << e.tag;
                    if (resp_valid !== eo || cyc != e.due || resp_div_by_zero !== e.dz ||
                        (!e.dz && resp_quotient !== W'(e.quo))) begin
                        failures++;
                        $display("FAIL resp_data: got valid=%b q=%0d dz=%b cyc=%0d, required valid=%b q=%0d dz=%b cyc=%0d",
                                 resp_valid, $signed(resp_quotient), resp_div_by_zero, cyc,
                                 eo, e.quo, e.dz, e.due);
                    end
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_ops(input int i, input int a, input int b);
        req_dividend[i*W +: W] = W'(a);
        req_divisor[i*W +: W]  = W'(b);
    endtask

    task automatic apply(input logic [NREQ-1:0] v, input logic en, input bit rnd);
        @(posedge clk);
        #1;
        if (rnd) begin
            for (int i = 0; i < NREQ; i++) begin
                set_ops(i, int'($urandom_range(254)) - 127, int'($urandom_range(16)) - 8);
            end
        end
        req_valid = v;
        enable    = en;
        @(negedge clk);
    endtask

    // Drives one cycle, returns the model's grant and records it.
    task automatic step(input logic [NREQ-1:0] v, input logic en, input bit rnd,
                        output logic [NREQ-1:0] g);
        apply(v, en, rnd);
        g = exp_grant(v, en);
        note_grant(g);
    endtask

    task automatic drain();
        @(posedge clk);
        #1;
        req_valid = '0;
        repeat (L + 4) @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rstn      = 1'b0;
        req_valid = '0;
        sb_q.delete();
        ref_ptr   = NREQ - 1;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        repeat (L + 2) @(negedge clk);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        req_valid = '1;
        enable    = 1'b1;
        #2;
        checks++;
        if ({req_ready, resp_valid, div_start, busy, tag_error, resp_quotient, div_dividend} !== '0) begin
            failures++;
            $display("FAIL reset_hold: ready=%b resp=%b start=%b busy=%b terr=%b, required all 0",
                     req_ready, resp_valid, div_start, busy, tag_error);
        end
        repeat (2) @(posedge clk);
        #1;
        req_valid = '0;
        rstn      = 1'b1;
        @(negedge clk);
        checks++;
        if ({req_ready, resp_valid, div_start, busy, tag_error} !== '0) begin
            failures++;
            $display("FAIL reset_release: ready=%b resp=%b start=%b busy=%b terr=%b, required all 0",
                     req_ready, resp_valid, div_start, busy, tag_error);
        end
        repeat (L + 2) @(negedge clk);
    endtask

    task automatic test_single();
        logic [NREQ-1:0] g;
        int              t0;
        set_ops(2, 100, 7);
        step(4'b0100, 1'b1, 1'b0, g);
        t0 = cyc;
        checks++;
        if (req_ready !== 4'b0100) begin
            failures++;
            $display("FAIL single_grant: req_ready=%b, required 0100", req_ready);
        end
        apply('0, 1'b1, 1'b0);
        checks++;
        if (div_start !== 1'b1 || div_dividend !== 8'd100 || div_divisor !== 8'd7) begin
            failures++;
            $display("FAIL single_issue: start=%b dividend=%0d divisor=%0d, required 1/100/7",
                     div_start, $signed(div_dividend), $signed(div_divisor));
        end
        for (int k = 0; k < L + 4; k++) begin
            @(negedge clk);
            if (resp_valid != '0) break;
        end
        checks++;
        if (resp_valid !== 4'b0100 || resp_quotient !== 8'd14 || (cyc - t0) != L + 2) begin
            failures++;
            $display("FAIL single_resp: valid=%b q=%0d latency=%0d, required 0100/14/%0d",
                     resp_valid, $signed(resp_quotient), cyc - t0, L + 2);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL single_busy: busy=%b after response, required 0", busy);
        end
    endtask

    task automatic test_all_four();
        logic [NREQ-1:0] g;
        int              c0;
        do_reset();
        set_ops(0, -64, 8);
        set_ops(1, 50, -5);
        set_ops(2, 9, 3);
        set_ops(3, 7, 0);
        c0 = resp_cnt;
        for (int k = 0; k < 8; k++) begin
            step('1, 1'b1, 1'b0, g);
            checks++;
            if (req_ready !== g) begin
                failures++;
                $display("FAIL all4_grant[%0d]: req_ready=%b, required %b", k, req_ready, g);
            end
        end
        drain();
        checks++;
        if (sb_q.size() != 0 || resp_cnt - c0 != 8) begin
            failures++;
            $display("FAIL all4_count: responses=%0d outstanding=%0d, required 8/0",
                     resp_cnt - c0, sb_q.size());
        end
    endtask

    task automatic test_enable_drop();
        logic [NREQ-1:0] g;
        int              c0;
        c0 = resp_cnt;
        for (int k = 0; k < 3; k++) begin
            step('1, 1'b1, 1'b1, g);
            checks++;
            if (req_ready !== g) begin
                failures++;
                $display("FAIL en_grant[%0d]: req_ready=%b, required %b", k, req_ready, g);
            end
        end
        for (int k = 0; k < L + 4; k++) begin
            step('1, 1'b0, 1'b1, g);
            checks++;
            if (req_ready !== '0) begin
                failures++;
                $display("FAIL en_blocked[%0d]: req_ready=%b, required 0000", k, req_ready);
            end
        end
        checks++;
        if (resp_cnt - c0 != 3) begin
            failures++;
            $display("FAIL en_count: responses=%0d, required 3", resp_cnt - c0);
        end
        for (int k = 0; k < 6; k++) begin
            step('1, 1'b1, 1'b1, g);
            checks++;
            if (req_ready !== g) begin
                failures++;
                $display("FAIL en_resume[%0d]: req_ready=%b, required %b", k, req_ready, g);
            end
        end
        drain();
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL en_drain: outstanding=%0d, required 0", sb_q.size());
        end
    endtask

    task automatic test_random();
        logic [NREQ-1:0] g;
        logic [NREQ-1:0] v;
        logic            en;
        for (int k = 0; k < 80; k++) begin
            v  = NREQ'($urandom);
            en = ($urandom_range(7) != 0);
            step(v, en, 1'b1, g);
            checks++;
            if (req_ready !== g) begin
                failures++;
                $display("FAIL rand_grant[%0d]: valid=%b en=%b req_ready=%b, required %b",
                         k, v, en, req_ready, g);
            end
        end
        drain();
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL rand_drain: outstanding=%0d, required 0", sb_q.size());
        end
    endtask

`ifdef AH_DIV_ARB_PRIO0_EN
    task automatic test_prio0();
        logic [NREQ-1:0] g;
        do_reset();
        for (int k = 0; k < 5; k++) begin
            step(4'b0011, 1'b1, 1'b1, g);
            checks++;
            if (req_ready !== 4'b0001) begin
                failures++;
                $display("FAIL prio0_grant[%0d]: req_ready=%b, required 0001", k, req_ready);
            end
        end
        step(4'b0010, 1'b1, 1'b1, g);
        checks++;
        if (req_ready !== 4'b0010) begin
            failures++;
            $display("FAIL prio0_release: req_ready=%b, required 0010", req_ready);
        end
        drain();
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL prio0_drain: outstanding=%0d, required 0", sb_q.size());
        end
    endtask
`endif

    task automatic test_spurious();
        checks++;
        if (tag_error !== 1'b0) begin
            failures++;
            $display("FAIL spur_pre: tag_error=%b, required 0", tag_error);
        end
        @(posedge clk);
        #1;
        inject = 1'b1;
        @(posedge clk);
        #1;
        inject = 1'b0;
        @(negedge clk);
        checks++;
        if (tag_error !== 1'b1 || resp_valid !== '0) begin
            failures++;
            $display("FAIL spur_set: tag_error=%b resp_valid=%b, required 1/0000", tag_error, resp_valid);
        end
        repeat (6) @(negedge clk);
        checks++;
        if (tag_error !== 1'b1) begin
            failures++;
            $display("FAIL spur_sticky: tag_error=%b, required 1", tag_error);
        end
    endtask

    task automatic test_reset_inflight();
        logic [NREQ-1:0] g;
        int              late;
        for (int k = 0; k < 5; k++) begin
            step('1, 1'b1, 1'b1, g);
            checks++;
            if (req_ready !== g) begin
                failures++;
                $display("FAIL inflight_grant[%0d]: req_ready=%b, required %b", k, req_ready, g);
            end
        end
        apply('0, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        rstn      = 1'b0;
        req_valid = '1;
        sb_q.delete();
        ref_ptr   = NREQ - 1;
        #1;
        checks++;
        if ({req_ready, resp_valid, div_start, busy, tag_error} !== '0) begin
            failures++;
            $display("FAIL inflight_reset: ready=%b resp=%b start=%b busy=%b terr=%b, required all 0",
                     req_ready, resp_valid, div_start, busy, tag_error);
        end
        repeat (2) @(posedge clk);
        #1;
        req_valid = '0;
        rstn      = 1'b1;
        late      = 0;
        for (int k = 0; k < L + 4; k++) begin
            @(negedge clk);
            if (div_data_valid) late++;
        end
        checks++;
        if (late != 5 || tag_error !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL inflight_late: late_pulses=%0d tag_error=%b busy=%b, required 5/0/0",
                     late, tag_error, busy);
        end
        set_ops(1, -90, 9);
        step(4'b0010, 1'b1, 1'b0, g);
        checks++;
        if (req_ready !== 4'b0010) begin
            failures++;
            $display("FAIL post_reset_grant: req_ready=%b, required 0010", req_ready);
        end
        drain();
        checks++;
        if (sb_q.size() != 0 || tag_error !== 1'b0) begin
            failures++;
            $display("FAIL post_reset_drain: outstanding=%0d tag_error=%b, required 0/0",
                     sb_q.size(), tag_error);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_all_four();
        test_enable_drop();
        test_random();
`ifdef AH_DIV_ARB_PRIO0_EN
        test_prio0();
`endif
        test_spurious();
        test_reset_inflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ah_div_pipe_arbiter.md
Name: ah_div_pipe_arbiter

Overview:
- Shares one pipelined 8-bit signed divider (the AH_DivPipelined family) among NREQ requesters.
- Grants one request per cycle, round-robin, and registers its operands onto the divider's start/dividend/divisor inputs.
- Tracks the requester ID of each in-flight operation in a tag pipeline matched to the divider latency.
- Steers each returning quotient/div_by_zero back to the originating requester as a one-cycle response pulse.

Parameters:
NREQ, 4, number of requesters (2..8)
WIDTH, 8, operand/quotient width
LATENCY, 11, divider cycles from div_start high to div_data_valid high
TAGW, 2, requester-index width, equal to clog2(NREQ)

Ports:
clk  in  1  clock, rising edge
rstn  in  1  asynchronous active-low reset
enable  in  1  1 = new grants allowed; in-flight operations always complete
req_valid  in  NREQ  per-requester request
req_dividend  in  NREQ*WIDTH  packed dividends, requester i at [i*WIDTH +: WIDTH]
req_divisor  in  NREQ*WIDTH  packed divisors, same packing
req_ready  out  NREQ  one-hot grant; handshake when req_valid[i] & req_ready[i]
resp_valid  out  NREQ  one-hot, one-cycle result pulse
resp_quotient  out  WIDTH  quotient, valid with any resp_valid bit
resp_div_by_zero  out  1  divide-by-zero flag, valid with any resp_valid bit
div_start  out  1  to divider start
div_dividend  out  WIDTH  to divider
div_divisor  out  WIDTH  to divider
div_data_valid  in  1  from divider
div_quotient  in  WIDTH  from divider
div_div_by_zero  in  1  from divider
busy  out  1  issue register or any tag stage valid
tag_error  out  1  sticky: divider valid does not match the tag pipeline

Behaviour:
- Reset (async, rstn low) clears all registers immediately. All outputs are 0 and the RR pointer is NREQ-1. In-flight operations are discarded; any div_data_valid in the first LATENCY cycles after reset release is ignored and does not set tag_error. An ignore counter, loaded with LATENCY at reset, implements this.
- Grant (combinational):
  - When enable=1, req_ready has exactly one bit set: the first requester with req_valid high, searching from ptr+1 upward and wrapping.
  - When enable=0 or no req_valid bit is high, req_ready=0.
  - req_ready does not depend on downstream state; the divider accepts one operation per cycle.
- Pointer: on a handshake, ptr becomes the granted index. Otherwise ptr holds.
- Issue stage (registered):
  - A handshake in cycle T drives div_start=1, div_dividend and div_divisor in cycle T+1.
  - Otherwise div_start=0 and the operand registers hold their values.
- Tag pipeline:
  - A LATENCY-deep shift register of {valid, tag}; it enters with div_start.
  - The head is aligned so that it presents at the cycle div_data_valid is expected.
- Response (registered):
  - When div_data_valid=1 and the head valid=1, then in the next cycle resp_valid[head tag]=1, resp_quotient=div_quotient and resp_div_by_zero=div_div_by_zero.
  - Total latency from handshake to resp_valid is LATENCY+2 cycles.
  - Back-to-back grants give back-to-back responses in grant order.
- tag_error: set when div_data_valid differs from the head valid, outside the post-reset ignore window. It stays set until reset. When div_data_valid=1 and head valid=0, no response is produced.
- busy = div_start OR any tag-stage valid OR any resp_valid.
- Boundaries:
  - A single requester holding req_valid high gets a grant every cycle.
  - With all requesters active, grant order is strict 0,1,2,3,0,...
  - enable falling mid-stream blocks new grants; already-issued responses still arrive.
  - Requesters have no response backpressure and must sink resp_valid unconditionally.

Optional Feature:
- Macro: AH_DIV_ARB_PRIO0_EN.
- Defined: requester 0 has absolute priority. Whenever req_valid[0]=1 and enable=1, it is granted, and ptr is not updated by a requester-0 grant. Requesters 1..NREQ-1 arbitrate round-robin among themselves.
- Undefined: pure round-robin over all NREQ requesters, as described above.

Test Plan:
- Reset, then requester 2 requests 100/7 once -> req_ready=4'b0100 in that cycle; div_start one cycle later with 100/7; resp_valid=4'b0100 and resp_quotient=14 at 13 cycles after the handshake; busy falls afterwards.
- All four requesters held valid for 8 cycles with operands -64/8, 50/-5, 9/3, 7/0 -> grants 0,1,2,3,0,1,2,3; responses in the same order, back-to-back: -8, -10, 3, div_by_zero=1 for requester 3.
- enable dropped 3 cycles into a continuous stream -> exactly 3 responses; no grants while enable=0; ptr resumes round-robin after enable=1.
- Divider model injects a spurious div_data_valid with an empty tag head -> tag_error=1 and stays 1; no resp_valid; rstn pulse clears it.
- rstn asserted with 5 operations in flight -> outputs 0 immediately; late div_data_valid pulses within LATENCY cycles of release produce no response and no tag_error.
- With AH_DIV_ARB_PRIO0_EN defined, requesters 0 and 1 held valid -> requester 0 granted every cycle and requester 1 starved; when requester 0 drops, requester 1 is granted on the next cycle.
